// File: rtl/ofdm_rx_byte_packer.sv
// Packs demapped QPSK dibits into bytes and buffers them in a FIFO toward the consumer.
// Define OFDM_RX_PACKER_STATS_EN to build the saturating delivered-byte counter.
module ofdm_rx_byte_packer #(
    parameter int unsigned fifo_depth_g = 16
) (
    input  logic                            sys_clk_i,
    input  logic                            sys_rst_i,
    input  logic                            sys_init_i,
    input  logic [1:0]                      rx_rcv_data_i,
    input  logic                            rx_rcv_data_valid_i,
    input  logic                            rx_symbols_start_i,
    output logic [7:0]                      byte_data_o,
    output logic                            byte_valid_o,
    input  logic                            byte_ready_i,
    output logic [$clog2(fifo_depth_g):0]   fifo_level_o,
    output logic                            overflow_o,
    output logic                            align_err_o,
    output logic [15:0]                     byte_count_o
);

    localparam int unsigned PtrW = $clog2(fifo_depth_g);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] FullLevel = LvlW'(fifo_depth_g);

    // Packer state: shift_q holds byte bits 7:2 while the byte is being assembled
    logic [1:0]      dib_cnt_q, dib_cnt_d;
    logic [5:0]      shift_q, shift_d;
    logic            push;
    logic            align_set;
    logic [7:0]      push_byte;

    // FIFO state
    logic [7:0]      mem_q [fifo_depth_g];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            overflow_q, overflow_d;
    logic            align_err_q, align_err_d;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            head_avail;

    always_comb begin
        dib_cnt_d = dib_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        align_set = 1'b0;
        push_byte = {shift_q, rx_rcv_data_i};
        if (rx_rcv_data_valid_i) begin
            if (rx_symbols_start_i && (dib_cnt_q != 2'd0)) begin
                // Symbol boundary inside a byte: restart assembly with this dibit
                align_set = 1'b1;
                shift_d   = {rx_rcv_data_i, 4'b0000};
                dib_cnt_d = 2'd1;
            end else begin
                unique case (dib_cnt_q)
                    2'd0: shift_d = {rx_rcv_data_i, 4'b0000};
                    2'd1: shift_d[3:2] = rx_rcv_data_i;
                    2'd2: shift_d[1:0] = rx_rcv_data_i;
                    2'd3: push = 1'b1;
                    default: ;
                endcase
                dib_cnt_d = dib_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        pop        = byte_valid_q & byte_ready_i;
        full       = (level_q == FullLevel);
        wr_en      = push & (~full | pop);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(wr_en);
        level_d    = level_q + LvlW'(wr_en) - LvlW'(pop);
        overflow_d = overflow_q | (push & full & ~pop);
        align_err_d = align_err_q | align_set;
        // Head register sees only entries written before this edge, giving one cycle of latency
        head_avail   = pop ? (level_q > LvlW'(1)) : (level_q != '0);
        byte_valid_d = head_avail;
        byte_data_d  = byte_data_q;
        if (head_avail) begin
            byte_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            dib_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            align_err_q  <= 1'b0;
        end else if (sys_init_i) begin
            dib_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            dib_cnt_q    <= dib_cnt_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            overflow_q   <= overflow_d;
            align_err_q  <= align_err_d;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (wr_en && !sys_rst_i && !sys_init_i) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign byte_data_o  = byte_data_q;
    assign byte_valid_o = byte_valid_q;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign align_err_o  = align_err_q;

`ifdef OFDM_RX_PACKER_STATS_EN
    logic [15:0] byte_count_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || sys_init_i) begin
            byte_count_q <= '0;
        end else if (pop && (byte_count_q != 16'hFFFF)) begin
            byte_count_q <= byte_count_q + 16'd1;
        end
    end

    assign byte_count_o = byte_count_q;
`else
    assign byte_count_o = '0;
`endif

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Directed self-checking bench for ofdm_rx_byte_packer at the default FIFO depth of 16.
module tb_ofdm_rx_byte_packer;

    localparam int Depth = 16;
    localparam int LvlW  = $clog2(Depth) + 1;

`ifdef OFDM_RX_PACKER_STATS_EN
    localparam int StatsOn = 1;
`else
    localparam int StatsOn = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            init = 1'b0;
    logic [1:0]      rx_data = 2'b00;
    logic            rx_valid = 1'b0;
    logic            rx_start = 1'b0;
    logic [7:0]      byte_data;
    logic            byte_valid;
    logic            byte_ready = 1'b0;
    logic [LvlW-1:0] fifo_level;
    logic            overflow;
    logic            align_err;
    logic [15:0]     byte_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx_q[$];

    ofdm_rx_byte_packer #(
        .fifo_depth_g(Depth)
    ) u_dut (
        .sys_clk_i          (clk),
        .sys_rst_i          (rst),
        .sys_init_i         (init),
        .rx_rcv_data_i      (rx_data),
        .rx_rcv_data_valid_i(rx_valid),
        .rx_symbols_start_i (rx_start),
        .byte_data_o        (byte_data),
        .byte_valid_o       (byte_valid),
        .byte_ready_i       (byte_ready),
        .fifo_level_o       (fifo_level),
        .overflow_o         (overflow),
        .align_err_o        (align_err),
        .byte_count_o       (byte_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge, so the falling edge sees what the next edge samples
    always @(negedge clk) begin
        if (!rst && !init && byte_valid && byte_ready) rx_q.push_back(byte_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_dibit(input logic [1:0] d, input logic start);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_start = start;
        tick();
        rx_valid = 1'b0;
        rx_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) send_dibit(b[7-2*k -: 2], 1'b0);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", 32'(byte_valid), 32'd0);
        check_eq("rst_data", 32'(byte_data), 32'h00);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_align", 32'(align_err), 32'd0);
        check_eq("rst_count", 32'(byte_count), 32'd0);

        // Dibits 3,0,2,1 -> 0xC9, visible one edge after the fourth dibit
        byte_ready = 1'b1;
        send_dibit(2'd3, 1'b1);
        send_dibit(2'd0, 1'b0);
        send_dibit(2'd2, 1'b0);
        send_dibit(2'd1, 1'b0);
        check_eq("lat_valid_n", 32'(byte_valid), 32'd0);
        check_eq("lat_level_n", 32'(fifo_level), 32'd1);
        tick();
        check_eq("lat_valid_n1", 32'(byte_valid), 32'd1);
        check_eq("lat_data_n1", 32'(byte_data), 32'hC9);
        idle(4);
        check_eq("c9_count", 32'(rx_q.size()), 32'd1);
        check_eq("c9_byte", 32'(rx_q[0]), 32'hC9);
        check_eq("c9_empty_valid", 32'(byte_valid), 32'd0);
        check_eq("c9_hold_data", 32'(byte_data), 32'hC9);

        // Symbol start mid-byte drops the partial and realigns
        pulse_init();
        rx_q.delete();
        send_dibit(2'd2, 1'b1);
        send_dibit(2'd0, 1'b0);
        send_dibit(2'd3, 1'b0);
        check_eq("align_pre", 32'(align_err), 32'd0);
        send_dibit(2'd1, 1'b1);
        for (int k = 0; k < 3; k++) send_dibit(2'd1, 1'b0);
        idle(4);
        check_eq("align_flag", 32'(align_err), 32'd1);
        check_eq("align_count", 32'(rx_q.size()), 32'd1);
        check_eq("align_byte", 32'(rx_q[0]), 32'h55);

        // Overflow: 17 bytes into a 16-deep FIFO with no consumer
        pulse_init();
        check_eq("init_align_clr", 32'(align_err), 32'd0);
        rx_q.delete();
        byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        tick();
        check_eq("ovf_level", 32'(fifo_level), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_head", 32'(byte_data), 32'h00);
        byte_ready = 1'b1;
        idle(24);
        check_eq("ovf_drained", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check_eq($sformatf("ovf_byte%0d", i), 32'(rx_q[i]), 32'(i));
        check_eq("ovf_level_end", 32'(fifo_level), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        check_eq("ovf_bytecount", 32'(byte_count), StatsOn ? 32'd16 : 32'd0);

        // Full FIFO with a simultaneous pop accepts the completing byte
        pulse_init();
        check_eq("init_ovf_clr", 32'(overflow), 32'd0);
        check_eq("init_count_clr", 32'(byte_count), 32'd0);
        rx_q.delete();
        byte_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_dibit(2'd2, 1'b0);
        send_dibit(2'd2, 1'b0);
        send_dibit(2'd1, 1'b0);
        check_eq("full_level", 32'(fifo_level), 32'd16);
        byte_ready = 1'b1;
        send_dibit(2'd1, 1'b0);
        byte_ready = 1'b0;
        check_eq("full_pp_level", 32'(fifo_level), 32'd16);
        check_eq("full_pp_ovf", 32'(overflow), 32'd0);
        check_eq("full_pp_head", 32'(byte_data), 32'h01);
        byte_ready = 1'b1;
        idle(24);
        check_eq("full_pp_total", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 16; i++) check_eq($sformatf("full_byte%0d", i), 32'(rx_q[i]), 32'(i));
        check_eq("full_last", 32'(rx_q[16]), 32'hA5);

        // Reset mid-byte with stored bytes discards everything
        pulse_init();
        rx_q.delete();
        byte_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_dibit(2'd3, 1'b0);
        send_dibit(2'd3, 1'b0);
        check_eq("prerst_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        byte_ready = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_valid", 32'(byte_valid), 32'd0);
        check_eq("midrst_data", 32'(byte_data), 32'h00);
        check_eq("midrst_level", 32'(fifo_level), 32'd0);
        check_eq("midrst_count", 32'(byte_count), 32'd0);
        byte_ready = 1'b0;
        send_dibit(2'd0, 1'b0);
        send_dibit(2'd1, 1'b0);
        send_dibit(2'd2, 1'b0);
        send_dibit(2'd3, 1'b0);
        check_eq("postrst_level", 32'(fifo_level), 32'd1);
        byte_ready = 1'b1;
        idle(4);
        check_eq("postrst_count", 32'(rx_q.size()), 32'd1);
        check_eq("postrst_byte", 32'(rx_q[0]), 32'h1B);

        // A dibit presented with sys_init is discarded
        rx_q.delete();
        init     = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 2'd3;
        tick();
        init     = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'h01);
        idle(4);
        check_eq("initdrop_count", 32'(rx_q.size()), 32'd1);
        check_eq("initdrop_byte", 32'(rx_q[0]), 32'h01);

        // Delivered-byte counter over 300 bytes
        pulse_init();
        rx_q.delete();
        byte_ready = 1'b1;
        for (int i = 0; i < 300; i++) send_byte(8'(i));
        idle(4);
        check_eq("stats_rx", 32'(rx_q.size()), 32'd300);
        check_eq("stats_count", 32'(byte_count), StatsOn ? 32'd300 : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
